// File: rtl/simple_exec_sequencer.sv
// simple_exec_sequencer: multi-cycle fetch/decode/exec/mem/wb control for the 16-bit SIMPLE core.
// Optional retired-instruction counter enabled by defining PERF_COUNTER_EN.
module simple_exec_sequencer #(
   parameter logic [15:0] RESET_PC      = 16'h0000,
   parameter logic [7:0]  FETCH_TIMEOUT = 8'd255
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   input  logic        imem_ack,
   input  logic [15:0] imem_rdata,
   output logic [15:0] pc,
   output logic [1:0]  alu_op1,
   output logic [2:0]  alu_op2,
   output logic [2:0]  alu_cond,
   output logic [3:0]  alu_opcode,
   output logic [3:0]  alu_d,
   output logic        sel_in1_pc,
   output logic        sel_in2_imm,
   input  logic [15:0] alu_out,
   input  logic        alu_s,
   input  logic        alu_z,
   input  logic        alu_c,
   input  logic        alu_v,
   input  logic        alu_hlt,
   output logic        flag_s,
   output logic        flag_z,
   output logic        flag_c,
   output logic        flag_v,
   output logic        rf_we,
   output logic [2:0]  rf_waddr,
   output logic [15:0] rf_wdata,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [15:0] dmem_addr,
   input  logic        dmem_ack,
   input  logic [15:0] dmem_rdata,
`ifdef PERF_COUNTER_EN
   output logic [31:0] retired_cnt,
`endif
   output logic        halted,
   output logic        fault
);
   typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;
   state_t      state_q, state_d;
   logic [15:0] pc_q, pc_d, ir_q, ir_d, res_q, res_d, ld_q, ld_d;
   logic [3:0]  flags_q, flags_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        halted_q, halted_d, fault_q, fault_d;
   logic        is_load, is_store, is_branch, is_li, is_alu, alu_wr, flag_upd, is_hlt, wr_en;
   assign is_load   = ir_q[15:14] == 2'b00;
   assign is_store  = ir_q[15:14] == 2'b01;
   assign is_alu    = ir_q[15:14] == 2'b11;
   assign is_branch = ir_q[15:14] == 2'b10 && (ir_q[13:11] == 3'b100 || ir_q[13:11] == 3'b111);
   assign is_li     = ir_q[15:14] == 2'b10 && ir_q[13:11] == 3'b000;
   // CMP (5) and opcode 7 only touch flags; 12-15 touch neither flags nor registers
   assign flag_upd  = is_alu && ir_q[7:4] < 4'd12;
   assign alu_wr    = flag_upd && ir_q[7:4] != 4'd5 && ir_q[7:4] != 4'd7;
   assign is_hlt    = is_alu && ir_q[7:4] == 4'd15;
   assign wr_en     = alu_wr || is_li || is_load;
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      ir_d     = ir_q;
      res_d    = res_q;
      ld_d     = ld_q;
      flags_d  = flags_q;
      cnt_d    = cnt_q;
      halted_d = halted_q;
      fault_d  = fault_q;
      case (state_q)
         S_FETCH: begin
            if (imem_ack) begin
               ir_d    = imem_rdata;
               cnt_d   = 8'd0;
               state_d = S_DECODE;
            end else begin
               cnt_d = cnt_q + 8'd1;
               if (cnt_d == FETCH_TIMEOUT) begin
                  fault_d  = 1'b1;
                  halted_d = 1'b1;
                  state_d  = S_HALT;
               end
            end
         end
         S_DECODE: state_d = S_EXEC;
         S_EXEC: begin
            res_d   = alu_out;
            flags_d = flag_upd ? {alu_s, alu_z, alu_c, alu_v} : flags_q;
            if (is_hlt && alu_hlt) begin
               halted_d = 1'b1;
               state_d  = S_HALT;
            end else begin
               state_d = (is_load || is_store) ? S_MEM : S_WB;
            end
         end
         S_MEM: begin
            if (dmem_ack) begin
               ld_d    = is_load ? dmem_rdata : ld_q;
               state_d = S_WB;
            end
         end
         S_WB: begin
            pc_d    = is_branch ? res_q : pc_q + 16'd1;
            state_d = S_FETCH;
         end
         default: state_d = S_HALT;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_FETCH;
         pc_q     <= RESET_PC;
         ir_q     <= 16'd0;
         res_q    <= 16'd0;
         ld_q     <= 16'd0;
         flags_q  <= 4'd0;
         cnt_q    <= 8'd0;
         halted_q <= 1'b0;
         fault_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         ir_q     <= ir_d;
         res_q    <= res_d;
         ld_q     <= ld_d;
         flags_q  <= flags_d;
         cnt_q    <= cnt_d;
         halted_q <= halted_d;
         fault_q  <= fault_d;
      end
   end
`ifdef PERF_COUNTER_EN
   logic [31:0] ret_q, ret_d;
   always_comb ret_d = (state_q == S_WB && ret_q != 32'hFFFF_FFFF) ? ret_q + 32'd1 : ret_q;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) ret_q <= 32'd0;
      else     ret_q <= ret_d;
   end
   assign retired_cnt = ret_q;
`endif
   assign imem_req    = state_q == S_FETCH;
   assign pc          = pc_q;
   assign alu_op1     = ir_q[15:14];
   assign alu_op2     = ir_q[13:11];
   assign alu_cond    = ir_q[10:8];
   assign alu_opcode  = ir_q[7:4];
   assign alu_d       = ir_q[3:0];
   assign sel_in1_pc  = is_branch;
   assign sel_in2_imm = ir_q[15:14] != 2'b11;
   assign {flag_s, flag_z, flag_c, flag_v} = flags_q;
   assign rf_we       = state_q == S_WB && wr_en;
   assign rf_waddr    = is_load ? ir_q[13:11] : ir_q[10:8];
   assign rf_wdata    = is_load ? ld_q : res_q;
   assign dmem_req    = state_q == S_MEM;
   assign dmem_we     = state_q == S_MEM && is_store;
   assign dmem_addr   = res_q;
   assign halted      = halted_q;
   assign fault       = fault_q;
endmodule

// File: tb/tb_simple_exec_sequencer.sv
// tb_simple_exec_sequencer: table-driven instruction stream with a scoreboard, plus halt/reset/timeout sequences.
module tb_simple_exec_sequencer;
   logic        clk = 1'b0, rst = 1'b1;
   logic        imem_req, imem_ack = 1'b0;
   logic [15:0] imem_rdata = 16'd0, pc;
   logic [1:0]  alu_op1;
   logic [2:0]  alu_op2, alu_cond;
   logic [3:0]  alu_opcode, alu_d;
   logic        sel_in1_pc, sel_in2_imm;
   logic [15:0] alu_out = 16'd0;
   logic        alu_s = 1'b0, alu_z = 1'b0, alu_c = 1'b0, alu_v = 1'b0, alu_hlt = 1'b0;
   logic        flag_s, flag_z, flag_c, flag_v;
   logic        rf_we;
   logic [2:0]  rf_waddr;
   logic [15:0] rf_wdata;
   logic        dmem_req, dmem_we;
   logic [15:0] dmem_addr;
   logic        dmem_ack = 1'b0;
   logic [15:0] dmem_rdata = 16'd0;
   logic        halted, fault;
   int          passed = 0, total = 0;

   simple_exec_sequencer dut (
      .clk(clk), .rst(rst), .imem_req(imem_req), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .pc(pc), .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_cond(alu_cond), .alu_opcode(alu_opcode),
      .alu_d(alu_d), .sel_in1_pc(sel_in1_pc), .sel_in2_imm(sel_in2_imm), .alu_out(alu_out),
      .alu_s(alu_s), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v), .alu_hlt(alu_hlt),
      .flag_s(flag_s), .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v), .rf_we(rf_we),
      .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .dmem_req(dmem_req), .dmem_we(dmem_we),
      .dmem_addr(dmem_addr), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .halted(halted), .fault(fault)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] inst;
      logic [15:0] aout;
      logic [3:0]  af;
      logic        hlt;
      logic [15:0] rdata;
      int          ack_cyc;
      logic        we;
      logic [2:0]  waddr;
      logic [15:0] wdata;
      logic [15:0] pc;
      logic [3:0]  fl;
      logic        s1;
      logic        s2;
      logic        dwe;
      logic        hl;
   } vec_t;

   vec_t vecs[11];
   vec_t exp_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run(input vec_t v);
      vec_t        e;
      logic        we_seen = 1'b0, dwe_seen = 1'b0, s1, s2, done = 1'b0;
      logic [2:0]  waddr_seen = 3'd0;
      logic [15:0] wdata_seen = 16'd0, daddr_seen = 16'd0, fields;
      int          memcyc = 0;
      chk("fetch_req", {31'd0, imem_req}, 32'd1);
      exp_q.push_back(v);
      alu_out = v.aout;
      {alu_s, alu_z, alu_c, alu_v} = v.af;
      alu_hlt = v.hlt;
      dmem_rdata = v.rdata;
      imem_rdata = v.inst;
      imem_ack = 1'b1;
      tick();
      imem_ack = 1'b0;
      s1 = sel_in1_pc;
      s2 = sel_in2_imm;
      fields = {alu_op1, alu_op2, alu_cond, alu_opcode, alu_d};
      for (int c = 0; c < 40 && !done; c++) begin
         if (dmem_req) begin
            memcyc++;
            dwe_seen = dmem_we;
            daddr_seen = dmem_addr;
            dmem_ack = (memcyc == v.ack_cyc);
         end else dmem_ack = 1'b0;
         if (rf_we) begin
            we_seen = 1'b1;
            waddr_seen = rf_waddr;
            wdata_seen = rf_wdata;
         end
         if (imem_req || halted) done = 1'b1;
         else tick();
      end
      dmem_ack = 1'b0;
      e = exp_q.pop_front();
      chk("complete", {31'd0, done}, 32'd1);
      chk("fields", {16'd0, fields}, {16'd0, e.inst});
      chk("sel_in1_pc", {31'd0, s1}, {31'd0, e.s1});
      chk("sel_in2_imm", {31'd0, s2}, {31'd0, e.s2});
      chk("rf_we", {31'd0, we_seen}, {31'd0, e.we});
      if (e.we) begin
         chk("rf_waddr", {29'd0, waddr_seen}, {29'd0, e.waddr});
         chk("rf_wdata", {16'd0, wdata_seen}, {16'd0, e.wdata});
      end
      chk("mem_cycles", memcyc, e.ack_cyc);
      if (e.ack_cyc > 0) begin
         chk("dmem_we", {31'd0, dwe_seen}, {31'd0, e.dwe});
         chk("dmem_addr", {16'd0, daddr_seen}, {16'd0, e.aout});
      end
      chk("pc", {16'd0, pc}, {16'd0, e.pc});
      chk("flags", {28'd0, flag_s, flag_z, flag_c, flag_v}, {28'd0, e.fl});
      chk("halted", {31'd0, halted}, {31'd0, e.hl});
   endtask

   initial begin
      int first;
      //          inst      aout      af     hlt  rdata     ack we waddr wdata     pc        fl     s1 s2 dwe hl
      vecs[0]  = '{16'hD100, 16'h0005, 4'b0000, 0, 16'h0000, 0, 1, 3'd1, 16'h0005, 16'h0001, 4'b0000, 0, 0, 0, 0};
      vecs[1]  = '{16'hC210, 16'h0000, 4'b0100, 0, 16'h0000, 0, 1, 3'd2, 16'h0000, 16'h0002, 4'b0100, 0, 0, 0, 0};
      vecs[2]  = '{16'h8307, 16'h0007, 4'b0000, 0, 16'h0000, 0, 1, 3'd3, 16'h0007, 16'h0003, 4'b0100, 0, 1, 0, 0};
      vecs[3]  = '{16'hB805, 16'h0010, 4'b1111, 0, 16'h0000, 0, 0, 3'd0, 16'h0000, 16'h0010, 4'b0100, 1, 1, 0, 0};
      vecs[4]  = '{16'hCC53, 16'h1234, 4'b1011, 0, 16'h0000, 0, 0, 3'd0, 16'h0000, 16'h0011, 4'b1011, 0, 0, 0, 0};
      vecs[5]  = '{16'hC0C0, 16'h5555, 4'b0000, 0, 16'h0000, 0, 0, 3'd0, 16'h0000, 16'h0012, 4'b1011, 0, 0, 0, 0};
      vecs[6]  = '{16'hC170, 16'h0001, 4'b0000, 0, 16'h0000, 0, 0, 3'd0, 16'h0000, 16'h0013, 4'b0000, 0, 0, 0, 0};
      vecs[7]  = '{16'hA0FF, 16'h0014, 4'b0000, 0, 16'h0000, 0, 0, 3'd0, 16'h0000, 16'h0014, 4'b0000, 1, 1, 0, 0};
      vecs[8]  = '{16'h2904, 16'h0040, 4'b1111, 0, 16'hBEEF, 3, 1, 3'd5, 16'hBEEF, 16'h0015, 4'b0000, 0, 1, 0, 0};
      vecs[9]  = '{16'h5002, 16'h0080, 4'b0000, 0, 16'h1111, 1, 0, 3'd0, 16'h0000, 16'h0016, 4'b0000, 0, 1, 1, 0};
      vecs[10] = '{16'hC0F0, 16'h0099, 4'b1111, 1, 16'h0000, 0, 0, 3'd0, 16'h0000, 16'h0016, 4'b0000, 0, 0, 0, 1};
      #2;
      chk("rst_pc", {16'd0, pc}, 32'd0);
      chk("rst_flags", {28'd0, flag_s, flag_z, flag_c, flag_v}, 32'd0);
      chk("rst_strobes", {29'd0, rf_we, dmem_req, dmem_we}, 32'd0);
      chk("rst_wb_regs", {13'd0, rf_waddr, rf_wdata}, 32'd0);
      chk("rst_dmem_addr", {16'd0, dmem_addr}, 32'd0);
      chk("rst_halt_fault", {30'd0, halted, fault}, 32'd0);
      tick();
      rst = 1'b0;
      tick();
      for (int i = 0; i < 11; i++) run(vecs[i]);
      chk("scoreboard_empty", exp_q.size(), 32'd0);
      for (int i = 0; i < 6; i++) begin
         imem_ack = i[0];
         tick();
      end
      imem_ack = 1'b0;
      chk("halt_pc_hold", {16'd0, pc}, 32'h0016);
      chk("halt_sticky", {30'd0, halted, imem_req}, 32'd2);
      rst = 1'b1;
      #1;
      chk("rst_pc_restore", {16'd0, pc}, 32'd0);
      chk("rst_halt_clear", {31'd0, halted}, 32'd0);
      tick();
      rst = 1'b0;
      tick();
      imem_rdata = 16'h2904;
      imem_ack = 1'b1;
      tick();
      imem_ack = 1'b0;
      tick();
      tick();
      chk("mem_req_before_rst", {31'd0, dmem_req}, 32'd1);
      rst = 1'b1;
      #1;
      chk("mem_req_async_drop", {31'd0, dmem_req}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < 250; i++) tick();
      chk("no_fault_250", {30'd0, fault, halted}, 32'd0);
      first = 0;
      for (int i = 251; i <= 270 && first == 0; i++) begin
         tick();
         if (fault) first = i;
      end
      chk("timeout_cycle", first, 32'd255);
      chk("timeout_fault_halt", {30'd0, fault, halted}, 32'd3);
      chk("timeout_no_req", {31'd0, imem_req}, 32'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/simple_exec_sequencer.md
Name: simple_exec_sequencer

Overview:
- Multi-cycle control sequencer for the 16-bit SIMPLE core; it is the driving and consuming end of the ALU interface.
- Fetches instruction words over a req/ack handshake, decodes them, and drives the ALU field inputs plus operand-select controls.
- Captures the ALU result and S/Z/C/V flags, holds the architectural flag register, and issues register-file write, data-memory and PC updates.
- Stops on HLT.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- FETCH_TIMEOUT, 255, max cycles waiting on imem_ack before the fault halt; 8-bit range.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- imem_req  out  1  instruction fetch request.
- imem_ack  in  1  fetch data valid; 1-cycle pulse.
- imem_rdata  in  16  instruction word.
- pc  out  16  current program counter; fetch address.
- alu_op1  out  2  inst[15:14].
- alu_op2  out  3  inst[13:11].
- alu_cond  out  3  inst[10:8].
- alu_opcode  out  4  inst[7:4].
- alu_d  out  4  inst[3:0].
- sel_in1_pc  out  1  ALU in1 = PC+1 (branch), else Rd/Rb.
- sel_in2_imm  out  1  ALU in2 = sign_ext(inst[7:0]), else Rs.
- alu_out  in  16  ALU result.
- alu_s, alu_z, alu_c, alu_v  in  1 each  ALU flag outputs.
- alu_hlt  in  1  ALU halt indication.
- flag_s, flag_z, flag_c, flag_v  out  1 each  flag register; feeds ALU S_in/Z_in/C_in/V_in.
- rf_we  out  1  register-file write strobe; 1 cycle.
- rf_waddr  out  3  write register index.
- rf_wdata  out  16  write data.
- dmem_req  out  1  data memory request.
- dmem_we  out  1  1 = store, 0 = load.
- dmem_addr  out  16  = captured alu_out.
- dmem_ack  in  1  data memory done; 1-cycle pulse.
- dmem_rdata  in  16  load data.
- halted  out  1  core halted; sticky.
- fault  out  1  fetch timeout occurred; sticky.

Behaviour:
- Reset, asynchronous, any state:
  - state=FETCH, pc=RESET_PC, ir=0.
  - All flags 0, all strobes 0, rf_waddr/rf_wdata/dmem_addr 0.
  - halted=0, fault=0, timeout counter 0.
- States: FETCH -> DECODE -> EXEC -> (MEM) -> WB -> FETCH; terminal HALT.
- FETCH:
  - imem_req=1; each cycle without imem_ack increments the counter.
  - On imem_ack: ir<=imem_rdata, counter cleared, go DECODE.
  - Counter reaching FETCH_TIMEOUT: fault=1, halted=1, go HALT.
- DECODE, 1 cycle: field outputs are driven from ir, registered, valid from DECODE onward and stable through WB.
- Operand selects:
  - sel_in1_pc=1 iff op1=10 and op2 is 100 or 111.
  - sel_in2_imm=1 iff op1 is 00/01, or op1=10.
- EXEC, 1 cycle: sample alu_out into result register.
  - Flags: update from alu_s/z/c/v only when op1=11 and opcode is not 12-15; otherwise hold.
  - alu_hlt=1 with op1=11, opcode=15: go HALT, no writeback, pc not advanced.
  - op1=00 (load) or 01 (store): go MEM; else go WB.
- MEM:
  - dmem_req=1, dmem_we=(op1==01), dmem_addr=result.
  - Store data on rf_wdata: Ra value is routed by the datapath; this block only sequences.
  - Wait indefinitely for dmem_ack; a load captures dmem_rdata.
- WB, 1 cycle:
  - rf_we=1, waddr=inst[10:8], wdata=result: op1=11 with opcode 0-4, 6, 8-11.
  - rf_we=1, waddr=inst[10:8], wdata=result: op1=10 with op2=000 (LI).
  - rf_we=1, waddr=inst[13:11], wdata=load data: op1=00.
  - Branch (op1=10, op2 100/111): pc<=result. The ALU already resolves the condition; not-taken returns PC+1.
  - All others: pc<=pc+1, wrapping 16'hFFFF -> 0.
- HALT: all strobes 0; remain until rst. imem_ack/dmem_ack are ignored outside FETCH/MEM.
- Latency per instruction: ALU op 4 cycles + fetch wait; load/store 5 + dmem wait.
- Opcode 5 (CMP): flags update, no writeback.

Optional Feature:
- Macro PERF_COUNTER_EN.
- When defined: adds output retired_cnt[31:0], reset 0, incremented once per WB cycle, saturating at 32'hFFFFFFFF; HLT is not counted.
- When undefined: port and logic absent.

Test Plan:
- ADD R1,R2: inst 16'hD100 with alu_out=16'h0005, flags 0000 -> rf_we pulse in WB, waddr=1, wdata=5; pc 0->1; flag_z=0.
- SUB sets Z: op1=11, opcode 1, alu_z=1 -> flag_z=1 after EXEC; following LI (16'h8307) leaves flag_z=1 and writes R3=alu_out.
- BE taken: flag_z=1, inst op1=10 op2=111 cond=000, alu_out=16'h0010 -> sel_in1_pc=1, pc=16'h0010 after WB, rf_we never asserted.
- Load with 3-cycle dmem stall: op1=00, dmem_ack on 3rd MEM cycle, dmem_rdata=16'hBEEF -> rf_wdata=16'hBEEF, waddr=inst[13:11], dmem_we=0.
- HLT: op1=11 opcode=15, alu_hlt=1 -> halted=1, pc unchanged; later imem_ack pulses ignored; rst restores pc=RESET_PC, halted=0.
- Reset mid-MEM and fetch timeout: rst during MEM -> dmem_req drops immediately. No imem_ack for 255 cycles -> fault=1, halted=1.
